// File: rtl/board_mem_responder.sv
// Avalon-MM word memory slave with pipelined fixed-latency reads, periodic backpressure and a preload port.
// Optional byte-lane writes are enabled with `define BOARD_MEM_BYTEEN_EN.
module board_mem_responder #(
   parameter int unsigned DEPTH        = 256,
   parameter int unsigned READ_LATENCY = 2,
   parameter int unsigned STALL_EVERY  = 0,
   parameter logic [31:0] OOR_DATA     = 32'hDEADBEEF
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [31:0]              slave_address,
   input  logic                     slave_read,
   input  logic                     slave_write,
   input  logic [31:0]              slave_writedata,
`ifdef BOARD_MEM_BYTEEN_EN
   input  logic [3:0]               slave_byteenable,
`endif
   output logic                     slave_waitrequest,
   output logic [31:0]              slave_readdata,
   output logic                     slave_readdatavalid,
   input  logic                     init_we,
   input  logic [$clog2(DEPTH)-1:0] init_addr,
   input  logic [31:0]              init_data,
   output logic [15:0]              rd_count,
   output logic [15:0]              wr_count,
   output logic                     err
);

   localparam int unsigned AW   = $clog2(DEPTH);
   localparam int unsigned HI_W = 30 - AW;
   localparam logic [15:0] STALL_LAST = (STALL_EVERY > 32'd0) ? 16'(STALL_EVERY - 32'd1) : 16'd0;

`ifdef BOARD_MEM_BYTEEN_EN
   function automatic logic [31:0] merge_lanes(input logic [31:0] old_w, input logic [31:0] new_w,
                                               input logic [3:0] be);
      logic [31:0] res;
      for (int b = 0; b < 4; b++) begin
         res[8*b +: 8] = be[b] ? new_w[8*b +: 8] : old_w[8*b +: 8];
      end
      return res;
   endfunction
`endif

   logic [31:0]   mem_q [DEPTH];
   logic          pipe_v_q    [READ_LATENCY];
   logic [31:0]   pipe_data_q [READ_LATENCY];

   logic          wait_q, wait_d;
   logic [15:0]   stall_cnt_q, stall_cnt_d;
   logic [15:0]   rd_count_q, rd_count_d;
   logic [15:0]   wr_count_q, wr_count_d;
   logic          err_q, err_d;

   logic          accept_s, wr_acc_s, rd_acc_s, both_s, in_range_s, stall_hit_s;
   logic [AW-1:0] word_s;
   logic [31:0]   rd_data_s, wr_word_s;
   logic          unused_addr_s;

   assign unused_addr_s = ^slave_address[1:0];
   assign word_s        = slave_address[AW+1:2];
   assign in_range_s    = (slave_address[31:AW+2] == {HI_W{1'b0}});

   // Command acceptance decode; a preload cycle blocks the slave port.
   always_comb begin
      accept_s  = (slave_read | slave_write) & ~wait_q & ~init_we;
      wr_acc_s  = accept_s & slave_write;
      rd_acc_s  = accept_s & slave_read & ~slave_write;
      both_s    = accept_s & slave_read & slave_write;
      rd_data_s = in_range_s ? mem_q[word_s] : OOR_DATA;
`ifdef BOARD_MEM_BYTEEN_EN
      wr_word_s = merge_lanes(mem_q[word_s], slave_writedata, slave_byteenable);
`else
      wr_word_s = slave_writedata;
`endif
   end

   // Next-state for backpressure, counters and sticky error.
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      stall_hit_s = 1'b0;
      if (accept_s && (STALL_EVERY != 32'd0)) begin
         if (stall_cnt_q == STALL_LAST) begin
            stall_hit_s = 1'b1;
            stall_cnt_d = 16'd0;
         end else begin
            stall_cnt_d = stall_cnt_q + 16'd1;
         end
      end else begin
         stall_cnt_d = stall_cnt_q;
      end
      wait_d = init_we | stall_hit_s;

      if (rd_acc_s && (rd_count_q != 16'hFFFF)) begin
         rd_count_d = rd_count_q + 16'd1;
      end else begin
         rd_count_d = rd_count_q;
      end
      if (wr_acc_s && (wr_count_q != 16'hFFFF)) begin
         wr_count_d = wr_count_q + 16'd1;
      end else begin
         wr_count_d = wr_count_q;
      end
      err_d = err_q | both_s | (accept_s & ~in_range_s);
   end

   // Control registers and read-return shift pipeline.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wait_q      <= 1'b1;
         stall_cnt_q <= 16'd0;
         rd_count_q  <= 16'd0;
         wr_count_q  <= 16'd0;
         err_q       <= 1'b0;
         for (int i = 0; i < READ_LATENCY; i++) begin
            pipe_v_q[i]    <= 1'b0;
            pipe_data_q[i] <= 32'd0;
         end
      end else begin
         wait_q         <= wait_d;
         stall_cnt_q    <= stall_cnt_d;
         rd_count_q     <= rd_count_d;
         wr_count_q     <= wr_count_d;
         err_q          <= err_d;
         pipe_v_q[0]    <= rd_acc_s;
         pipe_data_q[0] <= rd_data_s;
         for (int i = 1; i < READ_LATENCY; i++) begin
            pipe_v_q[i]    <= pipe_v_q[i-1];
            pipe_data_q[i] <= pipe_data_q[i-1];
         end
      end
   end

   // Storage array; contents survive reset.
   always_ff @(posedge clk) begin
      if (init_we) begin
         mem_q[init_addr] <= init_data;
      end else if (wr_acc_s && in_range_s) begin
         mem_q[word_s] <= wr_word_s;
      end
   end

   assign slave_waitrequest   = wait_q;
   assign slave_readdatavalid = pipe_v_q[READ_LATENCY-1];
   assign slave_readdata      = pipe_data_q[READ_LATENCY-1];
   assign rd_count            = rd_count_q;
   assign wr_count            = wr_count_q;
   assign err                 = err_q;

endmodule

// File: tb/tb_board_mem_responder.sv
// Randomized bench for board_mem_responder: two instances (no stall / stall every 3) vs. a transaction-level model.
module tb_board_mem_responder;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst = 1'b0;
   logic [31:0] addr, wdata, idata;
   logic        rd, wr, iwe;
   logic [3:0]  be;
   logic [7:0]  iaddr;

   logic [1:0]  wt, rv, er;
   logic [31:0] rdat [2];
   logic [15:0] rc [2];
   logic [15:0] wc [2];

   board_mem_responder #(.DEPTH(256), .READ_LATENCY(2), .STALL_EVERY(0), .OOR_DATA(32'hDEADBEEF)) dut0 (
      .clk(clk), .rst(rst), .slave_address(addr), .slave_read(rd), .slave_write(wr),
      .slave_writedata(wdata),
`ifdef BOARD_MEM_BYTEEN_EN
      .slave_byteenable(be),
`endif
      .slave_waitrequest(wt[0]), .slave_readdata(rdat[0]), .slave_readdatavalid(rv[0]),
      .init_we(iwe), .init_addr(iaddr), .init_data(idata),
      .rd_count(rc[0]), .wr_count(wc[0]), .err(er[0]));

   board_mem_responder #(.DEPTH(16), .READ_LATENCY(3), .STALL_EVERY(3), .OOR_DATA(32'hDEADBEEF)) dut1 (
      .clk(clk), .rst(rst), .slave_address(addr), .slave_read(rd), .slave_write(wr),
      .slave_writedata(wdata),
`ifdef BOARD_MEM_BYTEEN_EN
      .slave_byteenable(be),
`endif
      .slave_waitrequest(wt[1]), .slave_readdata(rdat[1]), .slave_readdatavalid(rv[1]),
      .init_we(iwe), .init_addr(iaddr[3:0]), .init_data(idata),
      .rd_count(rc[1]), .wr_count(wc[1]), .err(er[1]));

   int total = 0;
   int bad   = 0;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Reference model state, per instance
   int          dep  [2] = '{256, 16};
   int          lat  [2] = '{2, 3};
   int          kk   [2] = '{0, 3};
   logic [31:0] mm   [2][256];
   bit          ew   [2];
   int          acc_mod [2];
   int          erc  [2];
   int          ewc  [2];
   bit          eerr [2];
   bit          sv   [2][16];
   logic [31:0] sd   [2][16];
   int          edge_n = 0;

   function automatic logic [31:0] lane_write(input logic [31:0] old_w, input logic [31:0] new_w,
                                              input logic [3:0] lanes);
      logic [31:0] mask;
      mask = {{8{lanes[3]}}, {8{lanes[2]}}, {8{lanes[1]}}, {8{lanes[0]}}};
      return (old_w & ~mask) | (new_w & mask);
   endfunction

   task automatic model_edge(input int d);
      longint word;
      bit     inr, acc, stall;
      logic [3:0] lanes;
`ifdef BOARD_MEM_BYTEEN_EN
      lanes = be;
`else
      lanes = 4'hF;
`endif
      if (rst) begin
         ew[d] = 1'b1; acc_mod[d] = 0; erc[d] = 0; ewc[d] = 0; eerr[d] = 1'b0;
         for (int s = 0; s < 16; s++) sv[d][s] = 1'b0;
         return;
      end
      word  = longint'(addr) / 4;
      inr   = word < dep[d];
      acc   = (rd || wr) && !ew[d] && !iwe;
      stall = 1'b0;
      if (iwe) mm[d][int'(iaddr) % dep[d]] = idata;
      if (acc) begin
         if (!inr) eerr[d] = 1'b1;
         if (wr) begin
            if (ewc[d] < 65535) ewc[d]++;
            if (inr) mm[d][word] = lane_write(mm[d][word], wdata, lanes);
            if (rd) eerr[d] = 1'b1;
         end else begin
            if (erc[d] < 65535) erc[d]++;
            sv[d][(edge_n + lat[d] - 1) % 16] = 1'b1;
            sd[d][(edge_n + lat[d] - 1) % 16] = inr ? mm[d][word] : 32'hDEADBEEF;
         end
         if (kk[d] > 0) begin
            acc_mod[d]++;
            if (acc_mod[d] == kk[d]) begin
               acc_mod[d] = 0;
               stall = 1'b1;
            end
         end
      end
      ew[d] = iwe || stall;
   endtask

   task automatic check_outputs(input int d);
      int slot;
      slot = edge_n % 16;
      check_val($sformatf("d%0d_wait@%0d", d, edge_n), 32'(wt[d]), 32'(ew[d]));
      check_val($sformatf("d%0d_valid@%0d", d, edge_n), 32'(rv[d]), 32'(sv[d][slot]));
      if (sv[d][slot]) check_val($sformatf("d%0d_rdata@%0d", d, edge_n), rdat[d], sd[d][slot]);
      sv[d][slot] = 1'b0;
      check_val($sformatf("d%0d_rdcnt@%0d", d, edge_n), 32'(rc[d]), 32'(erc[d]));
      check_val($sformatf("d%0d_wrcnt@%0d", d, edge_n), 32'(wc[d]), 32'(ewc[d]));
      check_val($sformatf("d%0d_err@%0d", d, edge_n), 32'(er[d]), 32'(eerr[d]));
   endtask

   task automatic tick();
      @(posedge clk);
      edge_n++;
      for (int d = 0; d < 2; d++) model_edge(d);
      #1;
      for (int d = 0; d < 2; d++) check_outputs(d);
   endtask

   task automatic set_idle();
      rd = 1'b0; wr = 1'b0; iwe = 1'b0; be = 4'hF;
      addr = 32'd0; wdata = 32'd0; iaddr = 8'd0; idata = 32'd0;
   endtask

   task automatic do_reset();
      set_idle();
      @(negedge clk);
      rst = 1'b1;
      #1;
      for (int d = 0; d < 2; d++) begin
         check_val($sformatf("d%0d_rst_wait", d), 32'(wt[d]), 32'd1);
         check_val($sformatf("d%0d_rst_valid", d), 32'(rv[d]), 32'd0);
         check_val($sformatf("d%0d_rst_rdata", d), rdat[d], 32'd0);
      end
      tick();
      rst = 1'b0;
   endtask

   task automatic cmd(input logic r, input logic w, input logic [31:0] a, input logic [31:0] dat);
      rd = r; wr = w; addr = a; wdata = dat;
      tick();
      set_idle();
   endtask

   initial begin
      bit seen;
      set_idle();
      do_reset();
      // Known contents everywhere so random reads are predictable
      for (int i = 0; i < 256; i++) begin
         iwe = 1'b1; iaddr = 8'(i); idata = $urandom;
         tick();
      end
      set_idle();
      tick();

      // Write word 3 then read it back
      cmd(1'b0, 1'b1, 32'd12, 32'h00000005);
      cmd(1'b1, 1'b0, 32'd12, 32'd0);
      seen = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         if (!seen && rv[0]) begin
            seen = 1'b1;
            check_val("t1_rdata", rdat[0], 32'h00000005);
            check_val("t1_latency", 32'(i), 32'd0);
         end
      end
      check_val("t1_seen", 32'(seen), 32'd1);
      check_val("t1_wrcnt", 32'(wc[0]), 32'd1);
      check_val("t1_rdcnt", 32'(rc[0]), 32'd1);
      check_val("t1_err", 32'(er[0]), 32'd0);

      // Preload 0..63 then stream 64 back-to-back reads
      for (int i = 0; i < 64; i++) begin
         iwe = 1'b1; iaddr = 8'(i); idata = 32'(i + 1);
         tick();
      end
      set_idle();
      tick();
      for (int i = 0; i < 64; i++) begin
         rd = 1'b1; addr = 32'(i * 4);
         tick();
      end
      set_idle();
      repeat (6) tick();
      check_val("t2_rdcnt", 32'(rc[0]), 32'd65);

      // Back-to-back writes exercise the periodic stall
      for (int i = 0; i < 12; i++) begin
         wr = 1'b1; addr = 32'((100 + i) * 4); wdata = $urandom;
         tick();
      end
      set_idle();
      repeat (3) tick();

      // Write after read does not disturb the earlier read
      iwe = 1'b1; iaddr = 8'd5; idata = 32'hAA;
      tick();
      set_idle();
      tick();
      cmd(1'b1, 1'b0, 32'd20, 32'd0);
      cmd(1'b0, 1'b1, 32'd20, 32'hBB);
      tick();
      cmd(1'b1, 1'b0, 32'd20, 32'd0);
      repeat (5) tick();

      // Out of range read, then simultaneous read+write
      cmd(1'b1, 1'b0, 32'd1024, 32'd0);
      repeat (4) tick();
      check_val("t5_err", 32'(er[0]), 32'd1);
      cmd(1'b1, 1'b1, 32'd40, 32'h77);
      repeat (5) tick();

      // Reset with reads in flight; memory must survive
      cmd(1'b1, 1'b0, 32'd0, 32'd0);
      cmd(1'b1, 1'b0, 32'd4, 32'd0);
      do_reset();
      repeat (4) tick();
      check_val("t6_rdcnt", 32'(rc[0]), 32'd0);
      check_val("t6_wrcnt", 32'(wc[0]), 32'd0);
      for (int i = 0; i < 4; i++) cmd(1'b1, 1'b0, 32'(i * 4), 32'd0);
      repeat (5) tick();

`ifdef BOARD_MEM_BYTEEN_EN
      iwe = 1'b1; iaddr = 8'd7; idata = 32'hFFFFFFFF;
      tick();
      set_idle();
      tick();
      be = 4'b0010; wr = 1'b1; addr = 32'd28; wdata = 32'h11223344;
      tick();
      set_idle();
      tick();
      cmd(1'b1, 1'b0, 32'd28, 32'd0);
      seen = 1'b0;
      for (int i = 0; i < 6; i++) begin
         tick();
         if (!seen && rv[0]) begin
            seen = 1'b1;
            check_val("be_rdata", rdat[0], 32'hFFFF33FF);
         end
      end
      check_val("be_seen", 32'(seen), 32'd1);
`endif

      // Randomized traffic
      for (int n = 0; n < 3000; n++) begin
         if ($urandom_range(0, 599) == 0) begin
            do_reset();
         end else begin
            rd    = ($urandom_range(0, 2) == 0);
            wr    = ($urandom_range(0, 3) == 0);
            addr  = 32'($urandom_range(0, 299) * 4 + $urandom_range(0, 3));
            wdata = $urandom;
            be    = 4'($urandom);
            iwe   = ($urandom_range(0, 19) == 0);
            iaddr = 8'($urandom);
            idata = $urandom;
            tick();
         end
      end
      set_idle();
      repeat (6) tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/board_mem_responder.md
Name: board_mem_responder

Overview:
- Avalon-MM slave that models the board SDRAM serving a move-generator master (e.g. the pawn generator): it answers word reads and writes from the generator's master port.
- Pipelined reads with fixed latency, optional periodic backpressure, and a side preload port for loading initial boards.
- Used as the synthesizable memory-side peer for generator benches and on-chip board scratch storage.

Parameters:
- DEPTH, 256, number of 32-bit words; power of 2, 4..4096.
- READ_LATENCY, 2, cycles from read acceptance to readdatavalid; 1..8.
- STALL_EVERY, 0, insert one waitrequest cycle after every N accepted commands; 0 = never stall.
- OOR_DATA, 32'hDEADBEEF, read data returned for out-of-range addresses.

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- slave_address  in  32  byte address; word index = address[31:2]
- slave_read  in  1  read request
- slave_write  in  1  write request
- slave_writedata  in  32  write data
- slave_waitrequest  out  1  command not accepted this cycle
- slave_readdata  out  32  read data, valid with readdatavalid
- slave_readdatavalid  out  1  one-cycle pulse per accepted read
- init_we  in  1  preload write strobe
- init_addr  in  $clog2(DEPTH)  preload word index
- init_data  in  32  preload data
- rd_count  out  16  accepted reads, saturating
- wr_count  out  16  accepted writes, saturating
- err  out  1  sticky protocol/range error

Behaviour:
- Reset (async assert, sync release):
  - slave_waitrequest=1, slave_readdatavalid=0, slave_readdata=0, rd_count=0, wr_count=0, err=0.
  - Read pipeline flushed; in-flight reads are discarded and never return.
  - Memory contents are not cleared.
- slave_waitrequest is registered. It goes 0 on the first edge after rst deasserts.
- Acceptance: a command is accepted at an edge where (read|write)=1 and slave_waitrequest=0.
- Writes:
  - Accepted write updates mem[word] at that edge; wr_count++.
  - Address bits [1:0] are ignored.
- Reads:
  - Accepted read at edge N samples mem[word] at edge N; rd_count++.
  - slave_readdatavalid=1 with that data during the cycle after edge N+READ_LATENCY-1 (i.e. the cycle after edge N when READ_LATENCY=1).
  - Back-to-back reads are accepted every cycle; responses return in order, one per cycle.
  - The pipeline is a READ_LATENCY-deep shift register of {valid, data}.
- Read-after-write: a write at edge N followed by a read accepted at edge N+1 to the same word returns the new data.
- Write-after-read: a write accepted after a read's acceptance does not alter that read's returned data.
- Simultaneous read and write in one cycle: write performed, read dropped (no readdatavalid), err set, wr_count++ only.
- Out-of-range (word index ≥ DEPTH): write dropped; read returns OOR_DATA with normal latency; err set; counts still increment.
- Preload port:
  - init_we has priority over the slave port. In any cycle with init_we=1, mem[init_addr]←init_data.
  - slave_waitrequest is forced 1 in the following cycle, so no slave command is accepted in the same cycle as a preload.
  - The read pipeline continues draining during preload.
- Backpressure (STALL_EVERY=K>0):
  - A modulo-K counter of accepted commands.
  - When the K-th accepted command is accepted, slave_waitrequest=1 for exactly the next cycle, then 0; the counter wraps to 0.
  - Stall and preload-forced waitrequest overlap rather than extend each other.
- Counters saturate at 16'hFFFF.
- err clears only on rst.

Optional Feature:
- Macro: BOARD_MEM_BYTEEN_EN.
- Defined:
  - Adds port slave_byteenable, in, 4 bits.
  - Accepted writes update only byte lanes with byteenable=1; byteenable=0 on a write is a no-op that still counts.
  - Reads ignore byteenable and return the full word.
  - Lets generators write single squares (one byte per square).
- Undefined:
  - Port absent; all writes are full 32-bit.

Test Plan:
- Reset, then write word 3 = 32'h00000005 at address 12, then read address 12 with READ_LATENCY=2 → readdatavalid exactly 2 cycles after acceptance with readdata=32'h00000005; wr_count=1, rd_count=1, err=0.
- Preload words 0..63 with 0x01..0x40 via init_we, then issue 64 back-to-back reads of addresses 0,4,…,252 → 64 consecutive readdatavalid pulses, in order, data 0x01..0x40; no gaps with STALL_EVERY=0.
- STALL_EVERY=3 with 9 back-to-back writes → waitrequest high for one cycle after the 3rd, 6th and 9th acceptances; all 9 words written; wr_count=9.
- Read word 5 (=0xAA) accepted at edge N, write word 5 = 0xBB at edge N+1 → read returns 0xAA; a second read then returns 0xBB.
- Read address 4*DEPTH → OOR_DATA after READ_LATENCY, err=1. Simultaneous read+write → only the write lands, no readdatavalid, err stays 1.
- Assert rst while 2 reads are in flight → readdatavalid never pulses for them; after release, waitrequest=0 next cycle, counts 0, memory contents retained.
- With BOARD_MEM_BYTEEN_EN: write 32'h11223344 with byteenable=4'b0010 over 0xFFFFFFFF → word reads 32'hFFFF33FF.
